// File: rtl/dmem_resp_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_resp_if;
   logic        req;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_w;
   logic [2:0]  mem_op;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, addr, wdata, mem_w, mem_op,
                   input  ack, rdata, err);
   modport slave  (input  req, addr, wdata, mem_w, mem_op,
                   output ack, rdata, err);
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: word-organised RAM with RV32I byte/half/word
// access, req/ack handshake and a fixed number of wait states.
module dmem_resp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst,
   dmem_resp_if.slave bus
);
   localparam int          IW        = $clog2(DEPTH_WORDS);
   localparam int          AW        = IW + 2;
   // Address bits that must be zero for an in-range access (zero mask when AW=32).
   localparam logic [31:0] HI_MASK   = ~((32'd1 << AW) - 32'd1);
   localparam int          NUM_LANES = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mem_w;
      logic [2:0]  mem_op;
   } dmem_req_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                       state, state_nxt;
   logic [3:0]                   cnt, cnt_nxt;
   logic                         accept;
   logic                         commit;
   dmem_req_t                    in_req, req_q, cur;
   logic [NUM_LANES-1:0][7:0]    mem [DEPTH_WORDS];
   logic [IW-1:0]                idx;
   logic [31:0]                  word;
   logic [7:0]                   byte_sel;
   logic [15:0]                  half_sel;
   logic                         cur_err;
   logic                         op_bad;
   logic [NUM_LANES-1:0]         be;
   logic [NUM_LANES-1:0][7:0]    wbytes;
   logic [31:0]                  load_val;
   logic [31:0]                  rdata_q;
   logic                         err_q;

   assign in_req = '{addr: bus.addr, wdata: bus.wdata, mem_w: bus.mem_w, mem_op: bus.mem_op};

   // With no wait states accept and commit share an edge, so the live inputs
   // are the access; otherwise the latched copy is.
   assign cur = (WAIT_CYCLES == 0) ? in_req : req_q;

   assign bus.ack   = (state == S_RESP);
   assign bus.rdata = rdata_q;
   assign bus.err   = err_q;

   // Next-state, wait counter and accept decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         S_IDLE, S_RESP: begin
            if (bus.req) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES - 1);
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) state_nxt = S_RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The edge entering RESP is where the access takes effect.
   assign commit = (state_nxt == S_RESP);

   // State, counter and latched request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         req_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) req_q <= in_req;
      end
   end

   // Error decode: range, alignment and illegal funct3 / store-op combinations.
   always_comb begin
      case (cur.mem_op)
         3'b000:  op_bad = 1'b0;
         3'b001:  op_bad = cur.addr[0];
         3'b010:  op_bad = |cur.addr[1:0];
         3'b100:  op_bad = cur.mem_w;
         3'b101:  op_bad = cur.mem_w | cur.addr[0];
         default: op_bad = 1'b1;
      endcase
      cur_err = op_bad | (|(cur.addr & HI_MASK));
   end

   assign idx      = cur.addr[AW-1:2];
   assign word     = mem[idx];
   assign byte_sel = word[{cur.addr[1:0], 3'b000} +: 8];
   assign half_sel = cur.addr[1] ? word[31:16] : word[15:0];

   // Load extraction with sign/zero extension.
   always_comb begin
      case (cur.mem_op)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = word;
      endcase
   end

   // Store byte enables and lane-replicated write data.
   always_comb begin
      case (cur.mem_op[1:0])
         2'b00: begin
            be     = NUM_LANES'(1) << cur.addr[1:0];
            wbytes = {NUM_LANES{cur.wdata[7:0]}};
         end
         2'b01: begin
            be     = cur.addr[1] ? 4'b1100 : 4'b0011;
            wbytes = {2{cur.wdata[15:0]}};
         end
         default: begin
            be     = '1;
            wbytes = cur.wdata;
         end
      endcase
   end

   // RAM write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (commit && cur.mem_w && !cur_err) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) mem[idx][i] <= wbytes[i];
         end
      end
   end

   // Response registers; hold between acks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (commit) begin
         err_q   <= cur_err;
         rdata_q <= (cur_err || cur.mem_w) ? 32'd0 : load_val;
      end
   end
endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench: two responders (0 and 3 wait states) share clock/reset.
module tb_dmem_resp;
   localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                          OP_BU = 3'b100, OP_HU = 3'b101, OP_BAD = 3'b011;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q3[$];

   dmem_resp_if b0();
   dmem_resp_if b3();

   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
   dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pops one expectation per ack; the ack must land in the cycle ending at
   // edge accept+WAIT_CYCLES+1, i.e. cyc == accept cyc + WAIT_CYCLES at negedge.
   task automatic mon(input int d);
      exp_t        e;
      logic        a, er;
      logic [31:0] rd;
      int          n;
      forever begin
         @(negedge clk);
         a  = (d == 0) ? b0.ack   : b3.ack;
         rd = (d == 0) ? b0.rdata : b3.rdata;
         er = (d == 0) ? b0.err   : b3.err;
         n  = (d == 0) ? q0.size() : q3.size();
         if (rst && a) begin
            checks++;
            if (n == 0) begin
               errors++;
               $display("FAIL ack%0d_unexpected cyc=%0d rdata=%h err=%b", d, cyc, rd, er);
            end else begin
               e = (d == 0) ? q0.pop_front() : q3.pop_front();
               if (rd !== e.rdata || er !== e.err || cyc !== e.due) begin
                  errors++;
                  $display("FAIL resp%0d got rdata=%h err=%b cyc=%0d exp rdata=%h err=%b cyc=%0d",
                           d, rd, er, cyc, e.rdata, e.err, e.due);
               end
            end
         end
      end
   endtask

   // Presents one request; returns just after the edge that accepts it.
   task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic w, input logic [2:0] op,
                        input logic [31:0] er, input logic ee);
      exp_t e;
      if (d == 0) begin
         b0.req = 1'b1; b0.addr = a; b0.wdata = wd; b0.mem_w = w; b0.mem_op = op;
      end else begin
         b3.req = 1'b1; b3.addr = a; b3.wdata = wd; b3.mem_w = w; b3.mem_op = op;
      end
      @(posedge clk); #1;
      e.rdata = er;
      e.err   = ee;
      e.due   = cyc + ((d == 0) ? 0 : 3);
      if (d == 0) q0.push_back(e);
      else        q3.push_back(e);
   endtask

   task automatic drain(input int d);
      int n = 0;
      if (d == 0) b0.req = 1'b0;
      else        b3.req = 1'b0;
      while (((d == 0) ? q0.size() : q3.size()) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      #1;
      checks++;
      if (((d == 0) ? q0.size() : q3.size()) != 0) begin
         errors++;
         $display("FAIL drain%0d_timeout pending=%0d required=0", d,
                  (d == 0) ? q0.size() : q3.size());
         if (d == 0) q0.delete();
         else        q3.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({b0.ack, b0.err, b0.rdata} !== 34'd0) begin
         errors++;
         $display("FAIL reset0 got ack=%b err=%b rdata=%h required all 0", b0.ack, b0.err, b0.rdata);
      end
      checks++;
      if ({b3.ack, b3.err, b3.rdata} !== 34'd0) begin
         errors++;
         $display("FAIL reset3 got ack=%b err=%b rdata=%h required all 0", b3.ack, b3.err, b3.rdata);
      end
      #1 rst = 1'b1;
   endtask

   // Store then load of the same word back-to-back also covers read-after-write.
   task automatic test_back_to_back();
      issue(0, 32'h10, 32'hDEADBEEF, 1'b1, OP_W, 32'h0, 1'b0);
      issue(0, 32'h10, 32'h0,        1'b0, OP_W, 32'hDEADBEEF, 1'b0);
      drain(0);
   endtask

   task automatic test_lanes();
      issue(0, 32'h20, 32'h0,        1'b1, OP_W,  32'h0, 1'b0);
      issue(0, 32'h21, 32'h000000F0, 1'b1, OP_B,  32'h0, 1'b0);
      issue(0, 32'h22, 32'h00001234, 1'b1, OP_H,  32'h0, 1'b0);
      issue(0, 32'h20, 32'h0,        1'b0, OP_W,  32'h1234F000, 1'b0);
      issue(0, 32'h21, 32'h0,        1'b0, OP_B,  32'hFFFFFFF0, 1'b0);
      issue(0, 32'h21, 32'h0,        1'b0, OP_BU, 32'h000000F0, 1'b0);
      issue(0, 32'h22, 32'h0,        1'b0, OP_H,  32'h00001234, 1'b0);
      issue(0, 32'h23, 32'h0,        1'b0, OP_B,  32'h00000012, 1'b0);
      issue(0, 32'h24, 32'hFFFF0000, 1'b1, OP_W,  32'h0, 1'b0);
      issue(0, 32'h24, 32'hABCD8001, 1'b1, OP_H,  32'h0, 1'b0);
      issue(0, 32'h24, 32'h0,        1'b0, OP_W,  32'hFFFF8001, 1'b0);
      issue(0, 32'h24, 32'h0,        1'b0, OP_H,  32'hFFFF8001, 1'b0);
      issue(0, 32'h24, 32'h0,        1'b0, OP_HU, 32'h00008001, 1'b0);
      issue(0, 32'h26, 32'h0,        1'b0, OP_H,  32'hFFFFFFFF, 1'b0);
      issue(0, 32'h26, 32'h0,        1'b0, OP_HU, 32'h0000FFFF, 1'b0);
      drain(0);
   endtask

   task automatic test_errors();
      issue(0, 32'h22, 32'h11111111, 1'b1, OP_W,   32'h0, 1'b1);
      issue(0, 32'h20, 32'h0,        1'b0, OP_W,   32'h1234F000, 1'b0);
      issue(0, 32'h23, 32'h0,        1'b0, OP_H,   32'h0, 1'b1);
      issue(0, 32'h20, 32'h0,        1'b0, OP_BAD, 32'h0, 1'b1);
      issue(0, 32'h20, 32'h0,        1'b0, 3'b111, 32'h0, 1'b1);
      issue(0, 32'h20, 32'h000000AA, 1'b1, OP_BU,  32'h0, 1'b1);
      issue(0, 32'h21, 32'h0000BBBB, 1'b1, OP_H,   32'h0, 1'b1);
      issue(0, 32'h21, 32'h0,        1'b0, OP_W,   32'h0, 1'b1);
      issue(0, 32'h20, 32'h0,        1'b0, OP_W,   32'h1234F000, 1'b0);
      drain(0);
   endtask

   task automatic test_range();
      issue(0, 32'h1000,     32'h0,        1'b0, OP_W, 32'h0, 1'b1);
      issue(0, 32'h0FFC,     32'hA5A5A5A5, 1'b1, OP_W, 32'h0, 1'b0);
      issue(0, 32'h0FFC,     32'h0,        1'b0, OP_W, 32'hA5A5A5A5, 1'b0);
      issue(0, 32'h80000010, 32'h0,        1'b0, OP_W, 32'h0, 1'b1);
      issue(0, 32'h10,       32'h0,        1'b0, OP_W, 32'hDEADBEEF, 1'b0);
      drain(0);
   endtask

   // Store then load with wait states; inputs and req wander during WAIT.
   task automatic test_wait_states();
      exp_t e;
      b3.req = 1'b1; b3.addr = 32'h40; b3.wdata = 32'h5; b3.mem_w = 1'b1; b3.mem_op = OP_W;
      @(posedge clk); #1;
      e.rdata = 32'h0; e.err = 1'b0; e.due = cyc + 3;
      q3.push_back(e);
      b3.req = 1'b0; b3.addr = 32'h40; b3.wdata = 32'hFFFF; b3.mem_w = 1'b0;
      @(posedge clk); #1;
      b3.req = 1'b1;
      @(posedge clk); #1;
      b3.req = 1'b0;
      @(posedge clk); #1;
      b3.req = 1'b1;
      @(posedge clk); #1;
      e.rdata = 32'h5; e.err = 1'b0; e.due = cyc + 3;
      q3.push_back(e);
      drain(3);
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      issue(3, 32'h50, 32'h0, 1'b1, OP_W, 32'h0, 1'b0);
      drain(3);
      issue(3, 32'h40, 32'h0, 1'b0, OP_W, 32'h5, 1'b0);
      drain(3);
      b3.req = 1'b1; b3.addr = 32'h50; b3.wdata = 32'h77; b3.mem_w = 1'b1; b3.mem_op = OP_W;
      @(posedge clk); #1;
      b3.req = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({b3.ack, b3.err, b3.rdata} !== 34'd0) begin
         errors++;
         $display("FAIL reset_mid got ack=%b err=%b rdata=%h required all 0", b3.ack, b3.err, b3.rdata);
      end
      checks++;
      if ({b0.ack, b0.err, b0.rdata} !== 34'd0) begin
         errors++;
         $display("FAIL reset_mid0 got ack=%b err=%b rdata=%h required all 0", b0.ack, b0.err, b0.rdata);
      end
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (b3.ack) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL reset_mid_no_ack got acks=%0d required 0", acks);
      end
      issue(3, 32'h50, 32'h0, 1'b0, OP_W, 32'h0, 1'b0);
      drain(3);
   endtask

   initial begin
      b0.req = 1'b0; b0.addr = '0; b0.wdata = '0; b0.mem_w = 1'b0; b0.mem_op = OP_W;
      b3.req = 1'b0; b3.addr = '0; b3.wdata = '0; b3.mem_w = 1'b0; b3.mem_op = OP_W;
      fork
         begin mon(0); end
         begin mon(3); end
      join_none
      test_reset();
      test_back_to_back();
      test_lanes();
      test_errors();
      test_range();
      test_wait_states();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder serving the core's load/store port: the responder end of the interface the core drives with mem_op, mem_w, address and store data.
- Holds a word-organised RAM and performs byte, halfword and word accesses using RV32I funct3 semantics, including load sign/zero extension.
- Uses a req/ack handshake with a programmable number of wait states, so the same block models both single-cycle SRAM and slower memory.
- Reports misaligned, out-of-range and illegal-op accesses with an error flag instead of committing them.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, >= 2.
- WAIT_CYCLES, 0: extra cycles inserted between accept and response; range 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled when the block can accept.
- addr  in  32  byte address.
- wdata  in  32  store data, LSB-aligned; SB uses [7:0], SH uses [15:0].
- mem_w  in  1  1 = store, 0 = load.
- mem_op  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ack  out  1  one-cycle response strobe.
- rdata  out  32  load result, valid while ack=1.
- err  out  1  access error, valid while ack=1.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - RESP: ack=1 for exactly one cycle.
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, ack=0, rdata=0, err=0, latched request fields cleared. RAM contents are not reset.
- Accept:
  - A request is accepted on a rising edge when req=1 and state is IDLE or RESP; back-to-back requests are therefore allowed.
  - On accept, addr, wdata, mem_w and mem_op are latched; input changes after that edge are ignored.
- Transitions:
  - Accept with WAIT_CYCLES=0 -> RESP.
  - Accept with WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT: counter decrements each cycle; counter=0 -> RESP.
  - RESP: req=1 -> accept again as above; else -> IDLE.
  - req is ignored while in WAIT.
- Latency: ack asserts WAIT_CYCLES+1 cycles after the accept edge. Sustained throughput is one access per WAIT_CYCLES+1 cycles.
- Commit edge: the edge entering RESP. At this edge a store writes the RAM, or a load registers rdata and err.
- Word index and lanes:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store lanes: SB writes byte lane addr[1:0]; SH writes halfword lane addr[1]; SW writes all four bytes. All other bytes are unchanged.
  - Load: the selected byte/half is placed in the low bits. B/H sign-extend; BU/HU zero-extend; W returns the full word.
- Errors: err=1 if any of the following holds:
  - addr bits above log2(DEPTH_WORDS)+1 are nonzero (out of range);
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - mem_op is 011, 110 or 111;
  - a store uses op 100 or 101.
- On error: no RAM write, rdata=0, ack still asserted normally.
- Loads always return rdata; stores return rdata=0. When ack=0, rdata and err hold their last values.
- Read-after-write: a load accepted in RESP of a store to the same word returns the new data, because the store commits before the load's commit edge.
- Reset mid-operation (in WAIT): the pending access is abandoned, no write occurs and no ack is produced.

Test Plan:
- Reset then SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 (WAIT_CYCLES=0) -> each ack exactly 1 cycle after accept; load returns rdata=0xDEADBEEF, err=0.
- Byte lanes: SW 0x20=0x00000000; SB 0x21 wdata=0x000000F0; SH 0x22 wdata=0x00001234 -> LW 0x20 = 0x1234F000. LB 0x21 = 0xFFFFFFF0; LBU 0x21 = 0x000000F0; LH 0x22 = 0x00001234.
- Misaligned and illegal: SW 0x22 wdata=0x11111111 -> err=1, then LW 0x20 still 0x1234F000. LH 0x23 -> err=1, rdata=0. mem_op=011 -> err=1.
- Out of range (DEPTH_WORDS=1024): LW 0x1000 -> err=1, rdata=0. SW 0x0FFC=0xA5A5A5A5 then LW 0x0FFC -> 0xA5A5A5A5, err=0.
- WAIT_CYCLES=3, req held high for SW 0x40=0x5 then LW 0x40 -> acks 4 cycles apart, first ack 4 cycles after accept. Load returns 0x00000005. req toggling during WAIT is ignored.
- Reset mid-access: SW 0x50=0x77 issued with WAIT_CYCLES=3, rst=0 asserted asynchronously 1 cycle into WAIT -> ack, rdata and err go to 0 immediately and no ack follows. After release, LW 0x50 returns its prior value (pre-initialised to 0x0).
